dma_ctrl: RTL

Single-channel DMA engine that executes the `dmaCmd` / `dmaSrcAddress` / `dmaDstAddress` / `dmaWidth` requests issued by `simt_group`. It copies 32-bit words between external DRAM and the shared on-chip data SRAM in either direction: DRAM-to-SRAM (d2s) or SRAM-to-DRAM (s2d). While a transfer is in progress it stalls the SIMT group. It sits beside `sram_fp` and drives one SRAM port, which the top level muxes in while `stall` is high.

---
 rtl/dma_ctrl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/dma_ctrl.sv
// Single-channel DMA: copies 32-bit words DRAM->SRAM (d2s) or SRAM->DRAM (s2d), stalling the SIMT group.
// Latency: d2s 2 cycles/word, s2d 3 cycles/word with zero-wait DRAM; done pulses the cycle after the last word.
// Backpressure: each DRAM request is held stable until dramAck; stall stays high while a command is accepted or executing.
//
// Ports:
//   clk, reset                      - clock, asynchronous active-high reset
//   dmaCmd/dmaSrcAddress/
//   dmaDstAddress/dmaWidth          - command from simt_group (sampled only in IDLE)
//   stall, done                     - group stall (combinational), one-cycle completion pulse
//   dramAddress/dramReq/dramWe/
//   dramWriteData/dramReadData/
//   dramAck                         - single-outstanding DRAM word port
//   sramAddress/sramWriteEnable/
//   sramWriteData/sramReadData      - one port of the shared data SRAM (synchronous read)
module dma_ctrl #(
    parameter int SRAM_AW = 14
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         dmaCmd,
    input  logic [31:0]        dmaSrcAddress,
    input  logic [31:0]        dmaDstAddress,
    input  logic [9:0]         dmaWidth,
    output logic               stall,
    output logic               done,
    output logic [31:0]        dramAddress,
    output logic               dramReq,
    output logic               dramWe,
    output logic [31:0]        dramWriteData,
    input  logic [31:0]        dramReadData,
    input  logic               dramAck,
    output logic [SRAM_AW-1:0] sramAddress,
    output logic               sramWriteEnable,
    output logic [31:0]        sramWriteData,
    input  logic [31:0]        sramReadData
);

    typedef enum logic [2:0] {
        IDLE, D2S_REQ, D2S_WR, S2D_RD, S2D_CAP, S2D_REQ, DONE
    } state_t;

    localparam logic [1:0] CMD_D2S = 2'b01;
    localparam logic [1:0] CMD_S2D = 2'b10;

    state_t               state_q, state_d;
    // Addresses are kept as 30-bit word addresses; byte offsets are dropped.
    logic [29:0]          src_w_q, src_w_d;
    logic [29:0]          dst_w_q, dst_w_d;
    logic [9:0]           width_q, width_d;
    logic [9:0]           i_q, i_d;

    logic                 done_q, done_d;
    logic                 dram_req_q, dram_req_d;
    logic                 dram_we_q, dram_we_d;
    logic [31:0]          dram_addr_q, dram_addr_d;
    logic [31:0]          dram_wdata_q, dram_wdata_d;
    logic [SRAM_AW-1:0]   sram_addr_q, sram_addr_d;
    logic                 sram_we_q, sram_we_d;
    logic [31:0]          sram_wdata_q, sram_wdata_d;

    logic                 cmd_vld;
    logic [9:0]           i_nxt;
    logic [29:0]          src_nxt_w;   // src word address for the next word
    logic [29:0]          dst_cur_w;   // dst word address for the current word
    logic                 unused_addr_bits;

    assign cmd_vld   = (dmaCmd == CMD_D2S) || (dmaCmd == CMD_S2D);
    assign i_nxt     = i_q + 10'd1;
    // Word-address sums wrap naturally: modulo 2^30 words for DRAM, truncated to SRAM_AW for SRAM.
    assign src_nxt_w = src_w_q + {20'd0, i_nxt};
    assign dst_cur_w = dst_w_q + {20'd0, i_q};
    assign unused_addr_bits = ^{dmaSrcAddress[1:0], dmaDstAddress[1:0]};

    assign stall = ((state_q == IDLE) && cmd_vld) ||
                   ((state_q != IDLE) && (state_q != DONE));

    // Next-state and next-output logic; outputs are loaded on the edge that enters
    // the state they belong to, so they are registered (Moore) as seen outside.
    always_comb begin
        state_d      = state_q;
        src_w_d      = src_w_q;
        dst_w_d      = dst_w_q;
        width_d      = width_q;
        i_d          = i_q;
        done_d       = 1'b0;
        dram_req_d   = 1'b0;
        dram_we_d    = 1'b0;
        dram_addr_d  = dram_addr_q;
        dram_wdata_d = dram_wdata_q;
        sram_addr_d  = sram_addr_q;
        sram_we_d    = 1'b0;
        sram_wdata_d = sram_wdata_q;

        case (state_q)
            IDLE: begin
                if (cmd_vld) begin
                    src_w_d = dmaSrcAddress[31:2];
                    dst_w_d = dmaDstAddress[31:2];
                    width_d = dmaWidth;
                    i_d     = 10'd0;
                    if (dmaWidth == 10'd0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (dmaCmd == CMD_D2S) begin
                        state_d     = D2S_REQ;
                        dram_req_d  = 1'b1;
                        dram_addr_d = {dmaSrcAddress[31:2], 2'b00};
                    end else begin
                        state_d     = S2D_RD;
                        sram_addr_d = dmaSrcAddress[SRAM_AW+1:2];
                    end
                end
            end
            D2S_REQ: begin
                dram_req_d = 1'b1;
                if (dramAck) begin
                    state_d      = D2S_WR;
                    dram_req_d   = 1'b0;
                    sram_we_d    = 1'b1;
                    sram_addr_d  = dst_cur_w[SRAM_AW-1:0];
                    sram_wdata_d = dramReadData;
                end
            end
            D2S_WR: begin
                i_d = i_nxt;
                if (i_nxt == width_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d     = D2S_REQ;
                    dram_req_d  = 1'b1;
                    dram_addr_d = {src_nxt_w, 2'b00};
                end
            end
            S2D_RD: begin
                // SRAM samples the address at this edge; data appears in S2D_CAP.
                state_d = S2D_CAP;
            end
            S2D_CAP: begin
                state_d      = S2D_REQ;
                dram_req_d   = 1'b1;
                dram_we_d    = 1'b1;
                dram_addr_d  = {dst_cur_w, 2'b00};
                dram_wdata_d = sramReadData;
            end
            S2D_REQ: begin
                dram_req_d = 1'b1;
                dram_we_d  = 1'b1;
                if (dramAck) begin
                    dram_req_d = 1'b0;
                    dram_we_d  = 1'b0;
                    i_d        = i_nxt;
                    if (i_nxt == width_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = S2D_RD;
                        sram_addr_d = src_nxt_w[SRAM_AW-1:0];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            src_w_q      <= '0;
            dst_w_q      <= '0;
            width_q      <= '0;
            i_q          <= '0;
            done_q       <= 1'b0;
            dram_req_q   <= 1'b0;
            dram_we_q    <= 1'b0;
            dram_addr_q  <= '0;
            dram_wdata_q <= '0;
            sram_addr_q  <= '0;
            sram_we_q    <= 1'b0;
            sram_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            src_w_q      <= src_w_d;
            dst_w_q      <= dst_w_d;
            width_q      <= width_d;
            i_q          <= i_d;
            done_q       <= done_d;
            dram_req_q   <= dram_req_d;
            dram_we_q    <= dram_we_d;
            dram_addr_q  <= dram_addr_d;
            dram_wdata_q <= dram_wdata_d;
            sram_addr_q  <= sram_addr_d;
            sram_we_q    <= sram_we_d;
            sram_wdata_q <= sram_wdata_d;
        end
    end

    assign done            = done_q;
    assign dramReq         = dram_req_q;
    assign dramWe          = dram_we_q;
    assign dramAddress     = dram_addr_q;
    assign dramWriteData   = dram_wdata_q;
    assign sramAddress     = sram_addr_q;
    assign sramWriteEnable = sram_we_q;
    assign sramWriteData   = sram_wdata_q;

endmodule
